// File: rtl/fix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fix_pkg
// Description : Shared constants, message-length derivation and state
//               encoding for the FIX receive framer.
// Revision    : 1.0 - initial release
// ============================================================================
package fix_pkg;

    // ASCII bytes that drive the framing rules
    localparam logic [7:0] c_SOH      = 8'h01;
    localparam logic [7:0] c_ASCII_8  = 8'h38;
    localparam logic [7:0] c_ASCII_EQ = 8'h3D;
    localparam logic [7:0] c_ASCII_1  = 8'h31;
    localparam logic [7:0] c_ASCII_0  = 8'h30;
    localparam logic [7:0] c_ASCII_9  = 8'h39;

    // Default message geometry
    localparam int c_FIX_HEADER_LEN_DEF  = 42;
    localparam int c_FIX_PAYLOAD_LEN_DEF = 220;

    // The checksum trailer always carries exactly three decimal digits
    localparam int c_DIGIT_COUNT = 3;

    // Total message length is header plus payload; never set independently
    function automatic int fix_msg_len(input int hdr_len, input int pay_len);
        return hdr_len + pay_len;
    endfunction

    typedef enum logic [3:0] {
        ST_HUNT   = 4'd0,
        ST_SYNC   = 4'd1,
        ST_BODY   = 4'd2,
        ST_TAG1   = 4'd3,
        ST_TAG0   = 4'd4,
        ST_TAGEQ  = 4'd5,
        ST_DIGITS = 4'd6,
        ST_END    = 4'd7,
        ST_EMIT   = 4'd8
    } fix_state_t;

endpackage
`default_nettype wire

// File: rtl/fix_cksum_acc.sv
`default_nettype none
// ============================================================================
// Module      : fix_cksum_acc
// Description : Running modulo-256 byte sum of a FIX frame, with a snapshot
//               register (sum_soh) taken at each candidate trailer SOH.
// Revision    : 1.0 - initial release
// ============================================================================
module fix_cksum_acc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_add,
    input  logic       i_latch,
    input  logic [7:0] i_data,
    output logic [7:0] o_sum_soh
);

    logic [7:0] r_sum;
    logic [7:0] w_base;
    logic [7:0] w_sum_next;

    // A clear restarts the sum so the first byte of a new frame is added to 0
    assign w_base     = i_clear ? 8'h00 : r_sum;
    assign w_sum_next = w_base + i_data;

    // Accumulate stored bytes and snapshot the sum (including the SOH itself)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum     <= 8'h00;
            o_sum_soh <= 8'h00;
        end else begin
            if (i_add) begin
                r_sum <= w_sum_next;
            end else if (i_clear) begin
                r_sum <= 8'h00;
            end
            if (i_add && i_latch) begin
                o_sum_soh <= w_sum_next;
            end else if (i_clear) begin
                o_sum_soh <= 8'h00;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fix_rx_framer.sv
`default_nettype none
// ============================================================================
// Module      : fix_rx_framer
// Description : Extracts FIX messages ("8=" ... SOH "10=ddd" SOH) from a byte
//               stream, verifies the trailer checksum and presents each good
//               message as one packed vector with a single-cycle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module fix_rx_framer
    import fix_pkg::*;
#(
    parameter  int FIX_PAYLOAD_LEN = c_FIX_PAYLOAD_LEN_DEF,
    parameter  int FIX_HEADER_LEN  = c_FIX_HEADER_LEN_DEF,
    localparam int MSG_LEN         = fix_msg_len(FIX_HEADER_LEN, FIX_PAYLOAD_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 rx_enable,
    output logic [MSG_LEN*8-1:0] rx_fix_data,
    output logic [8:0]           msg_len,
    output logic                 cksum_err,
    output logic                 ovf_err,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          err_cnt
);

    // msg_len is 9 bits wide, so MSG_LEN must stay below 512
    localparam logic [8:0] c_IDX_FULL  = 9'(MSG_LEN);
    localparam logic [1:0] c_DIGIT_END = 2'(c_DIGIT_COUNT - 1);

    fix_state_t           r_state;
    fix_state_t           w_state_next;
    logic [MSG_LEN*8-1:0] r_buf;
    logic [MSG_LEN*8-1:0] w_buf_wr;
    logic [8:0]           r_idx;
    logic [9:0]           r_val;
    logic [1:0]           r_dcnt;
    logic                 r_bad;
    logic [7:0]           w_sum_soh;

    logic w_accept;
    logic w_full;
    logic w_is_digit;
    logic w_sum_match;
    logic w_store;
    logic w_clear;
    logic w_latch;
    logic w_ovf;
    logic w_cerr;
    logic w_emit;
    logic w_dig_start;
    logic w_dig_step;

    assign s_ready     = (r_state != ST_EMIT);
    assign w_accept    = s_valid && s_ready;
    assign w_full      = (r_idx == c_IDX_FULL);
    assign w_is_digit  = (s_data >= c_ASCII_0) && (s_data <= c_ASCII_9);
    assign w_sum_match = !r_bad && (r_val[9:8] == 2'b00) && (r_val[7:0] == w_sum_soh);

    fix_cksum_acc u_cksum (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .i_add     (w_store),
        .i_latch   (w_latch),
        .i_data    (s_data),
        .o_sum_soh (w_sum_soh)
    );

    // Working buffer with the current byte merged in at the write index;
    // also feeds the output register so the final SOH is included on emit
    always_comb begin
        w_buf_wr = r_buf;
        if (!w_full) begin
            w_buf_wr[(MSG_LEN - 1 - int'(r_idx)) * 8 +: 8] = s_data;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_state_next = r_state;
        w_store      = 1'b0;
        w_clear      = 1'b0;
        w_latch      = 1'b0;
        w_ovf        = 1'b0;
        w_cerr       = 1'b0;
        w_emit       = 1'b0;
        w_dig_start  = 1'b0;
        w_dig_step   = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_accept && (s_data == c_ASCII_8)) begin
                    w_store      = 1'b1;
                    w_clear      = 1'b1;
                    w_state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (w_accept) begin
                    if (s_data == c_ASCII_EQ) begin
                        w_store      = 1'b1;
                        w_state_next = ST_BODY;
                    end else begin
                        w_state_next = ST_HUNT;
                    end
                end
            end
            ST_EMIT: begin
                w_state_next = ST_HUNT;
            end
            default: begin
                if (w_accept) begin
                    if (w_full) begin
                        // No room for this byte: the frame is too long
                        w_ovf        = 1'b1;
                        w_state_next = ST_HUNT;
                    end else begin
                        w_store = 1'b1;
                        case (r_state)
                            ST_BODY: begin
                                if (s_data == c_SOH) begin
                                    w_latch      = 1'b1;
                                    w_state_next = ST_TAG1;
                                end
                            end
                            ST_TAG1, ST_TAG0, ST_TAGEQ: begin
                                if ((r_state == ST_TAG1) && (s_data == c_ASCII_1)) begin
                                    w_state_next = ST_TAG0;
                                end else if ((r_state == ST_TAG0) && (s_data == c_ASCII_0)) begin
                                    w_state_next = ST_TAGEQ;
                                end else if ((r_state == ST_TAGEQ) && (s_data == c_ASCII_EQ)) begin
                                    w_dig_start  = 1'b1;
                                    w_state_next = ST_DIGITS;
                                end else if (s_data == c_SOH) begin
                                    // A new field boundary: it may precede the trailer
                                    w_latch      = 1'b1;
                                    w_state_next = ST_TAG1;
                                end else begin
                                    w_state_next = ST_BODY;
                                end
                            end
                            ST_DIGITS: begin
                                w_dig_step = 1'b1;
                                if (r_dcnt == c_DIGIT_END) begin
                                    w_state_next = ST_END;
                                end
                            end
                            ST_END: begin
                                if ((s_data == c_SOH) && w_sum_match) begin
                                    w_emit       = 1'b1;
                                    w_state_next = ST_EMIT;
                                end else begin
                                    w_cerr       = 1'b1;
                                    w_state_next = ST_HUNT;
                                end
                            end
                            default: begin
                                w_state_next = ST_HUNT;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    // Frame buffer, trailer digit decode, outputs and saturating counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf       <= '0;
            r_idx       <= 9'd0;
            r_val       <= 10'd0;
            r_dcnt      <= 2'd0;
            r_bad       <= 1'b0;
            rx_enable   <= 1'b0;
            cksum_err   <= 1'b0;
            ovf_err     <= 1'b0;
            rx_fix_data <= '0;
            msg_len     <= 9'd0;
            frame_cnt   <= 16'd0;
            err_cnt     <= 16'd0;
        end else begin
            rx_enable <= w_emit;
            cksum_err <= w_cerr;
            ovf_err   <= w_ovf;

            if (w_store) begin
                if (w_clear) begin
                    r_buf <= {s_data, {((MSG_LEN - 1) * 8){1'b0}}};
                    r_idx <= 9'd1;
                end else begin
                    r_buf <= w_buf_wr;
                    r_idx <= r_idx + 9'd1;
                end
            end

            if (w_dig_start) begin
                r_val  <= 10'd0;
                r_dcnt <= 2'd0;
                r_bad  <= 1'b0;
            end else if (w_dig_step) begin
                r_val  <= (r_val * 10'd10) + {2'b00, s_data - c_ASCII_0};
                r_dcnt <= r_dcnt + 2'd1;
                if (!w_is_digit) begin
                    r_bad <= 1'b1;
                end
            end

            if (w_emit) begin
                rx_fix_data <= w_buf_wr;
                msg_len     <= r_idx + 9'd1;
                if (frame_cnt != 16'hFFFF) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end

            if ((w_cerr || w_ovf) && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fix_rx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fix_rx_framer
// Description : Self-checking bench for fix_rx_framer. Frames are generated
//               from FIX field rules, checksums computed by plain summation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fix_rx_framer;

    localparam int MSG_LEN = 262;
    localparam int W       = MSG_LEN * 8;

    typedef logic [7:0] byte_q [$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          rx_enable;
    logic [W-1:0]  rx_fix_data;
    logic [8:0]    msg_len;
    logic          cksum_err;
    logic          ovf_err;
    logic [15:0]   frame_cnt;
    logic [15:0]   err_cnt;

    fix_rx_framer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .rx_enable   (rx_enable),
        .rx_fix_data (rx_fix_data),
        .msg_len     (msg_len),
        .cksum_err   (cksum_err),
        .ovf_err     (ovf_err),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int exp_frames = 0;
    int exp_errs = 0;
    int last_acc = 0;
    int stalls = 0;

    // Event monitor, sampled on the falling edge
    int           ce_cnt = 0, ce_cyc = 0, ov_cnt = 0, ov_cyc = 0, en_cyc = 0;
    logic [W-1:0] cap_q [$];
    int           len_q [$];
    always @(negedge clk) begin
        if (rx_enable) begin
            cap_q.push_back(rx_fix_data);
            len_q.push_back(int'(msg_len));
            en_cyc = cyc;
        end
        if (cksum_err) begin ce_cnt++; ce_cyc = cyc; end
        if (ovf_err)   begin ov_cnt++; ov_cyc = cyc; end
    end

    // ---------------- reference model: frame construction ----------------
    function automatic void add_str(inout byte_q q, input string s);
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endfunction

    function automatic int sum_mod(input byte_q q);
        int s = 0;
        foreach (q[i]) s = (s + int'(q[i])) % 256;
        return s;
    endfunction

    // Header plus fields, ending in the SOH that precedes the trailer.
    // target_len > 0 sizes the whole frame (with 7-byte trailer) exactly.
    function automatic void make_body(input int target_len, output byte_q q);
        q = {};
        add_str(q, "8=FIX.4.4");
        q.push_back(8'h01);
        if (target_len > 0) begin
            add_str(q, "58=");
            for (int i = 0; i < target_len - 21; i++) q.push_back(8'(65 + $urandom_range(25)));
            q.push_back(8'h01);
        end else begin
            int nf = int'($urandom_range(1, 4));
            for (int f = 0; f < nf; f++) begin
                int tag = int'($urandom_range(20, 99));
                int nl  = int'($urandom_range(1, 8));
                q.push_back(8'(48 + tag / 10));
                q.push_back(8'(48 + tag % 10));
                q.push_back(8'h3D);
                for (int i = 0; i < nl; i++) q.push_back(8'(65 + $urandom_range(25)));
                q.push_back(8'h01);
            end
        end
    endfunction

    function automatic void add_trailer(inout byte_q q, input int value);
        add_str(q, "10=");
        q.push_back(8'(48 + (value / 100) % 10));
        q.push_back(8'(48 + (value / 10) % 10));
        q.push_back(8'(48 + value % 10));
        q.push_back(8'h01);
    endfunction

    function automatic logic [W-1:0] pack(input byte_q q);
        logic [W-1:0] v = '0;
        for (int k = 0; k < q.size(); k++) v[W-1-8*k -: 8] = q[k];
        return v;
    endfunction

    function automatic void spec_frame(input int cks, output byte_q q);
        q = {};
        add_str(q, "8=A");
        q.push_back(8'h01);
        add_trailer(q, cks);
    endfunction

    // ---------------- stimulus ----------------
    task automatic send(input byte_q q, input int gap_pct, input bit drop_valid);
        for (int i = 0; i < q.size(); i++) begin
            bit done  = 1'b0;
            int guard = 0;
            while (!done) begin
                @(negedge clk);
                if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                    s_valid = 1'b0;
                    s_data  = 8'($urandom);
                end else begin
                    s_valid = 1'b1;
                    s_data  = q[i];
                    if (s_ready) begin
                        last_acc = cyc;
                        done     = 1'b1;
                    end else begin
                        stalls++;
                    end
                end
                guard++;
                if (!done && guard > 500) begin
                    n_checks++; n_errors++;
                    $display("FAIL send_timeout: byte %0d never accepted, required acceptance within 500 cycles", i);
                    s_valid = 1'b0;
                    return;
                end
            end
        end
        if (drop_valid) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        s_valid = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (s_ready !== 1'b1) begin n_errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        n_checks++; if (rx_enable !== 1'b0) begin n_errors++; $display("FAIL reset_rx_enable: got %b want 0", rx_enable); end
        n_checks++; if (cksum_err !== 1'b0 || ovf_err !== 1'b0) begin n_errors++; $display("FAIL reset_err_pulses: got %b%b want 00", cksum_err, ovf_err); end
        n_checks++; if (msg_len !== 9'd0) begin n_errors++; $display("FAIL reset_msg_len: got %0d want 0", msg_len); end
        n_checks++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", frame_cnt, err_cnt); end
        n_checks++; if (rx_fix_data !== '0) begin n_errors++; $display("FAIL reset_rx_fix_data: got nonzero want 0"); end
    endtask

    task automatic test_good_frame;
        byte_q q;
        int    e0 = cap_q.size();
        spec_frame(183, q);
        n_checks++; if (sum_mod(q[0:3]) != 183) begin n_errors++; $display("FAIL model_sum: got %0d want 183", sum_mod(q[0:3])); end
        send(q, 0, 1);
        idle(3);
        exp_frames++;
        n_checks++; if (cap_q.size() - e0 != 1) begin n_errors++; $display("FAIL good_en_count: got %0d want 1", cap_q.size() - e0); end
        n_checks++; if (en_cyc != last_acc + 1) begin n_errors++; $display("FAIL good_latency: got cycle %0d want %0d", en_cyc, last_acc + 1); end
        n_checks++; if (msg_len !== 9'd11) begin n_errors++; $display("FAIL good_msg_len: got %0d want 11", msg_len); end
        n_checks++; if (rx_fix_data !== pack(q)) begin n_errors++; $display("FAIL good_data: got %h want %h", rx_fix_data[W-1 -: 88], pack(q) >> (W - 88)); end
        n_checks++; if (frame_cnt !== 16'(exp_frames) || err_cnt !== 16'(exp_errs)) begin n_errors++; $display("FAIL good_counters: got %0d/%0d want %0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs); end
    endtask

    task automatic test_bad_cksum;
        byte_q q, g, b;
        int    e0, c0, s;
        // Three failure kinds: wrong value, value above 255 aliasing mod 256, non-digit
        for (int v = 0; v < 3; v++) begin
            e0 = cap_q.size();
            c0 = ce_cnt;
            if (v == 0) begin
                spec_frame(184, q);
            end else begin
                make_body(0, b);
                s = sum_mod(b);
                q = b;
                if (v == 1) add_trailer(q, s + 256);
                else begin
                    add_str(q, "10=1A3");
                    q.push_back(8'h01);
                end
            end
            send(q, 0, 1);
            idle(3);
            exp_errs++;
            n_checks++; if (ce_cnt - c0 != 1) begin n_errors++; $display("FAIL bad%0d_cksum_pulses: got %0d want 1", v, ce_cnt - c0); end
            n_checks++; if (ce_cyc != last_acc + 1) begin n_errors++; $display("FAIL bad%0d_cksum_timing: got cycle %0d want %0d", v, ce_cyc, last_acc + 1); end
            n_checks++; if (cap_q.size() != e0) begin n_errors++; $display("FAIL bad%0d_no_enable: got %0d want 0", v, cap_q.size() - e0); end
            n_checks++; if (err_cnt !== 16'(exp_errs)) begin n_errors++; $display("FAIL bad%0d_err_cnt: got %0d want %0d", v, err_cnt, exp_errs); end
        end
        spec_frame(183, g);
        e0 = cap_q.size();
        send(g, 0, 1);
        idle(3);
        exp_frames++;
        n_checks++; if (cap_q.size() - e0 != 1 || rx_fix_data !== pack(g)) begin n_errors++; $display("FAIL bad_recovery: got %0d enables want 1 with matching data", cap_q.size() - e0); end
        n_checks++; if (frame_cnt !== 16'(exp_frames)) begin n_errors++; $display("FAIL bad_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_garbage;
        byte_q q, g;
        int    e0 = cap_q.size();
        int    c0 = ce_cnt + ov_cnt;
        add_str(q, "XY8Q");
        spec_frame(183, g);
        foreach (g[i]) q.push_back(g[i]);
        send(q, 0, 1);
        idle(3);
        exp_frames++;
        n_checks++; if (cap_q.size() - e0 != 1) begin n_errors++; $display("FAIL garbage_en_count: got %0d want 1", cap_q.size() - e0); end
        n_checks++; if (msg_len !== 9'd11 || rx_fix_data !== pack(g)) begin n_errors++; $display("FAIL garbage_frame: got len %0d want 11 with matching data", msg_len); end
        n_checks++; if (ce_cnt + ov_cnt != c0 || err_cnt !== 16'(exp_errs)) begin n_errors++; $display("FAIL garbage_no_error: got err_cnt %0d want %0d", err_cnt, exp_errs); end
    endtask

    task automatic test_overflow;
        byte_q q, g;
        int    e0 = cap_q.size();
        int    o0 = ov_cnt;
        add_str(q, "8=");
        for (int i = 0; i < MSG_LEN - 1; i++) q.push_back(8'(65 + $urandom_range(25)));
        send(q, 0, 1);
        idle(3);
        exp_errs++;
        n_checks++; if (ov_cnt - o0 != 1) begin n_errors++; $display("FAIL ovf_pulses: got %0d want 1", ov_cnt - o0); end
        n_checks++; if (ov_cyc != last_acc + 1) begin n_errors++; $display("FAIL ovf_timing: got cycle %0d want %0d", ov_cyc, last_acc + 1); end
        n_checks++; if (cap_q.size() != e0 || err_cnt !== 16'(exp_errs)) begin n_errors++; $display("FAIL ovf_state: got %0d enables err_cnt %0d want 0 and %0d", cap_q.size() - e0, err_cnt, exp_errs); end
        make_body(MSG_LEN, g);
        add_trailer(g, sum_mod(g));
        send(g, 0, 1);
        idle(3);
        exp_frames++;
        n_checks++; if (cap_q.size() - e0 != 1) begin n_errors++; $display("FAIL full_len_enable: got %0d want 1", cap_q.size() - e0); end
        n_checks++; if (msg_len !== 9'(MSG_LEN) || rx_fix_data !== pack(g)) begin n_errors++; $display("FAIL full_len_frame: got len %0d want %0d with matching data", msg_len, MSG_LEN); end
    endtask

    task automatic test_random_gaps;
        byte_q q;
        int    e0;
        for (int f = 0; f < 4; f++) begin
            make_body(0, q);
            add_trailer(q, sum_mod(q));
            e0 = cap_q.size();
            send(q, 40, 1);
            idle(3);
            exp_frames++;
            n_checks++; if (cap_q.size() - e0 != 1) begin n_errors++; $display("FAIL gaps%0d_en_count: got %0d want 1", f, cap_q.size() - e0); end
            n_checks++; if (en_cyc != last_acc + 1) begin n_errors++; $display("FAIL gaps%0d_latency: got cycle %0d want %0d", f, en_cyc, last_acc + 1); end
            n_checks++; if (msg_len !== 9'(q.size()) || rx_fix_data !== pack(q)) begin n_errors++; $display("FAIL gaps%0d_frame: got len %0d want %0d with matching data", f, msg_len, q.size()); end
        end
        n_checks++; if (frame_cnt !== 16'(exp_frames)) begin n_errors++; $display("FAIL gaps_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_back_to_back;
        byte_q q1, q2;
        int    e0 = cap_q.size();
        int    st0 = stalls;
        make_body(0, q1);
        add_trailer(q1, sum_mod(q1));
        make_body(0, q2);
        add_trailer(q2, sum_mod(q2));
        send(q1, 0, 0);
        send(q2, 0, 1);
        idle(3);
        exp_frames += 2;
        n_checks++; if (cap_q.size() - e0 != 2) begin n_errors++; $display("FAIL b2b_en_count: got %0d want 2", cap_q.size() - e0); end
        else begin
            n_checks++; if (cap_q[e0] !== pack(q1) || len_q[e0] != q1.size()) begin n_errors++; $display("FAIL b2b_first: got len %0d want %0d with matching data", len_q[e0], q1.size()); end
            n_checks++; if (cap_q[e0+1] !== pack(q2) || len_q[e0+1] != q2.size()) begin n_errors++; $display("FAIL b2b_second: got len %0d want %0d with matching data", len_q[e0+1], q2.size()); end
        end
        n_checks++; if (stalls - st0 != 1) begin n_errors++; $display("FAIL b2b_emit_stall: got %0d stalled cycles want 1", stalls - st0); end
        n_checks++; if (frame_cnt !== 16'(exp_frames)) begin n_errors++; $display("FAIL b2b_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_reset_midframe;
        byte_q p, g;
        make_body(0, p);
        send(p[0:5], 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (rx_fix_data !== '0 || msg_len !== 9'd0 || frame_cnt !== 16'd0) begin n_errors++; $display("FAIL midreset_clear: got len %0d frames %0d want 0 0", msg_len, frame_cnt); end
        rst_n = 1'b1;
        exp_frames = 0;
        exp_errs   = 0;
        spec_frame(183, g);
        send(g, 0, 1);
        idle(3);
        exp_frames++;
        n_checks++; if (msg_len !== 9'd11 || rx_fix_data !== pack(g)) begin n_errors++; $display("FAIL midreset_frame: got len %0d want 11 with matching data", msg_len); end
        n_checks++; if (frame_cnt !== 16'd1 || err_cnt !== 16'd0) begin n_errors++; $display("FAIL midreset_counters: got %0d/%0d want 1/0", frame_cnt, err_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_cksum();
        test_garbage();
        test_overflow();
        test_random_gaps();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fix_rx_framer.md
FIX_RX_FRAMER -- requirements
Module: fix_rx_framer

Interface
REQ-001 SHALL have parameter FIX_PAYLOAD_LEN, default 220, payload bytes per message.
REQ-002 SHALL have parameter FIX_HEADER_LEN, default 42, header bytes per message.
REQ-003 SHALL derive MSG_LEN = FIX_HEADER_LEN + FIX_PAYLOAD_LEN (262 by default); it is not overridable.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port s_data  in  8  inbound TCP payload byte.
REQ-007 SHALL have port s_valid  in  1  s_data valid.
REQ-008 SHALL have port s_ready  out  1  framer accepts byte; a byte transfers when s_valid and s_ready are both high.
REQ-009 SHALL have port rx_enable  out  1  one-cycle pulse, complete message available; drives fix_top rx_enable.
REQ-010 SHALL have port rx_fix_data  out  MSG_LEN*8  packed message; drives fix_top rx_fix_data.
REQ-011 SHALL have port msg_len  out  9  byte count of last emitted message.
REQ-012 SHALL have port cksum_err  out  1  one-cycle pulse, trailer checksum mismatch.
REQ-013 SHALL have port ovf_err  out  1  one-cycle pulse, frame exceeded MSG_LEN.
REQ-014 SHALL have port frame_cnt  out  16  good frames emitted; saturates at 0xFFFF.
REQ-015 SHALL have port err_cnt  out  16  cksum_err plus ovf_err events; saturates at 0xFFFF.

Function
REQ-016 SHALL implement the states HUNT, SYNC, BODY, TAG1, TAG0, TAGEQ, DIGITS, END and EMIT.
REQ-017 SHALL, in HUNT, discard bytes until '8' (0x38), then clear the buffer, store '8' at byte index 0, and go to SYNC.
REQ-018 SHALL, in SYNC, go to BODY when the next byte is '='; any other byte SHALL return the block to HUNT with no error pulse.
REQ-019 SHALL, in BODY, store every accepted byte; SOH (0x01) SHALL latch sum_soh = running sum including that SOH, then go to TAG1.
REQ-020 SHALL detect the trailer through TAG1 ('1'), TAG0 ('0') and TAGEQ ('='); a mismatching byte SHALL return to BODY, and a mismatching SOH SHALL re-latch sum_soh and stay in TAG1.
REQ-021 SHALL, in DIGITS, accept exactly 3 bytes and accumulate their value as value*10 + (byte-0x30) in a 10-bit register; it SHALL then go to END.
REQ-022 SHALL flag a checksum error when a non-digit byte arrives in DIGITS; the error pulse SHALL occur on the END byte.
REQ-023 SHALL, in END, require SOH; a match with a digit value equal to sum_soh[7:0] SHALL go to EMIT; any mismatch (value above 255, bad digit, or non-SOH) SHALL pulse cksum_err and return to HUNT.
REQ-024 SHALL keep the running checksum as an 8-bit modulo-256 sum of all stored bytes from index 0.
REQ-025 SHALL store byte k at rx_fix_data[MSG_LEN*8-1-8k -: 8], leaving unused low bytes zero.
REQ-026 SHALL pulse ovf_err and go to HUNT when the byte at index MSG_LEN arrives in any storing state; a message of exactly MSG_LEN bytes is legal.
REQ-027 SHALL, in EMIT, hold s_ready low, pulse rx_enable, update msg_len, increment frame_cnt, and return to HUNT the next cycle.
REQ-028 SHALL assert rx_enable exactly one cycle after the final SOH is accepted.
REQ-029 SHALL hold rx_fix_data and msg_len stable from EMIT until the next EMIT; the working buffer SHALL be separate from the output register.
REQ-030 SHALL hold s_ready high in every state except EMIT; gaps in s_valid SHALL NOT alter state.
REQ-031 SHALL increment err_cnt once per error pulse.

Reset
REQ-032 SHALL, when rst_n is low at a clk edge, set state to HUNT, set all outputs and counters to 0, set s_ready to 1, and discard any partial frame.

Structure
REQ-033 SHALL place the ASCII constants (SOH, '8', '=', '1', '0', '0'..'9' bounds), MSG_LEN derivation and state encoding in shared package fix_pkg.
REQ-034 SHALL instantiate one sub-module, fix_cksum_acc, holding the running 8-bit sum and sum_soh, with clear, add and latch controls.

Verification
REQ-035 SHALL verify: stream "8=A",0x01,"10=183",0x01 (11 bytes) -> rx_enable 1 cycle after last byte, msg_len=11, top 11 bytes of rx_fix_data match, frame_cnt=1.
REQ-036 SHALL verify: same frame with "10=184" -> cksum_err pulse, no rx_enable, err_cnt=1, and a following good frame decodes.
REQ-037 SHALL verify: bytes "XY8Q" then the good frame -> garbage ignored, a single rx_enable, msg_len=11.
REQ-038 SHALL verify: 263 bytes starting "8=" with no trailer -> ovf_err on byte 263, state HUNT; a legal 262-byte frame -> rx_enable.
REQ-039 SHALL verify: good frame with random s_valid gaps, plus s_valid held high across EMIT -> byte accepted only when s_ready is high, none lost, output identical.
REQ-040 SHALL verify: rst_n low after 6 bytes of a frame, then the good frame -> no stale data, msg_len=11, frame_cnt=1.
